// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC bus arbiter: state encoding, widths, port indices
// and the round-robin pick helper.
package rtc_bus_pkg;

  localparam int DATA_W        = 8;
  localparam int CNT_W         = 4;
  localparam int PHASE_CYC_DEF = 4;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_GAP  = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // On a tie the port that did not win last time goes next.
  function automatic logic rr_pick(input logic r0, input logic r1, input logic last);
    if (r0 && r1) return (last == PORT1) ? PORT0 : PORT1;
    return r0 ? PORT0 : PORT1;
  endfunction

endpackage

// File: rtl/rtc_bus_arbiter_phase_timer.sv
// Loadable down-counter timing one bus phase; term is high on the phase's last cycle.
module phase_timer
  import rtc_bus_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             term
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign term = (cnt == '0);

endmodule

// File: rtl/rtc_bus_arbiter.sv
// Two-port arbiter sharing one multiplexed RTC address/data bus; each grant runs a
// full ADDR/GAP/DATA/DONE cycle with strobes decoded from the registered state.
module rtc_bus_arbiter
  import rtc_bus_pkg::*;
#(
  parameter int PHASE_CYC = PHASE_CYC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              rw0,
  input  logic [DATA_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              done0,
  input  logic              req1,
  input  logic              rw1,
  input  logic [DATA_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              c_s,
  output logic              a_d,
  output logic              r_d,
  output logic              w_r,
  inout  wire  [DATA_W-1:0] io_port
);

  localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(PHASE_CYC - 1);

  logic [2:0]        state;
  logic              grant;
  logic              rw_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              win;
  logic              start;
  logic              tmr_load;
  logic              tmr_term;
  logic              drive_en;
  logic [DATA_W-1:0] drive_val;

  assign win      = rr_pick(req0, req1, grant);
  assign start    = (state == ST_IDLE) && (req0 || req1);
  assign tmr_load = start || (tmr_term && (state == ST_ADDR || state == ST_GAP));

  phase_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (PHASE_LAST),
    .term     (tmr_term)
  );

  // grant doubles as the round-robin history; reset to port 1 so port 0 wins the first tie
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      grant <= PORT1;
      rw_q  <= 1'b0;
      rdata <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          grant <= win;
          rw_q  <= (win == PORT1) ? rw1 : rw0;
          state <= ST_ADDR;
        end
        ST_ADDR: if (tmr_term) state <= ST_GAP;
        ST_GAP:  if (tmr_term) state <= ST_DATA;
        ST_DATA: if (tmr_term) begin
          state <= ST_DONE;
          if (!rw_q) rdata <= io_port;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      addr_q  <= (win == PORT1) ? addr1  : addr0;
      wdata_q <= (win == PORT1) ? wdata1 : wdata0;
    end
  end

  always_comb begin
    c_s       = 1'b1;
    a_d       = 1'b1;
    r_d       = 1'b1;
    w_r       = 1'b1;
    drive_en  = 1'b0;
    drive_val = addr_q;
    case (state)
      ST_ADDR: begin
        c_s      = 1'b0;
        a_d      = 1'b0;
        w_r      = 1'b0;
        drive_en = 1'b1;
      end
      ST_DATA: begin
        c_s = 1'b0;
        if (rw_q) begin
          w_r       = 1'b0;
          drive_en  = 1'b1;
          drive_val = wdata_q;
        end else begin
          r_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign io_port = drive_en ? drive_val : {DATA_W{1'bz}};
  assign done0   = (state == ST_DONE) && (grant == PORT0);
  assign done1   = (state == ST_DONE) && (grant == PORT1);

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Directed bench for rtc_bus_arbiter: vector table for single transactions plus
// hand-written tie, reset-abort and PHASE_CYC=1 sequences.
module tb_rtc_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       req0, rw0, req1, rw1;
  logic [7:0] addr0, wdata0, addr1, wdata1;
  logic       done0, done1;
  logic [7:0] rdata;
  logic       c_s, a_d, r_d, w_r;
  wire  [7:0] io_port;
  logic [7:0] rtc_data;

  logic       p_req0, p_rw0;
  logic [7:0] p_addr0, p_wdata0;
  logic       p_done0, p_done1;
  logic [7:0] p_rdata;
  logic       p_c_s, p_a_d, p_r_d, p_w_r;
  wire  [7:0] p_io;

  // RTC model answers reads; pull-ups make an undriven bus read as 8'hFF
  assign io_port = (!c_s && !r_d) ? rtc_data : 8'hzz;
  pullup (io_port);
  pullup (p_io);

  rtc_bus_arbiter u_dut (
    .clk(clk), .reset(reset),
    .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0), .done0(done0),
    .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1), .done1(done1),
    .rdata(rdata), .c_s(c_s), .a_d(a_d), .r_d(r_d), .w_r(w_r), .io_port(io_port)
  );

  rtc_bus_arbiter #(.PHASE_CYC(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .req0(p_req0), .rw0(p_rw0), .addr0(p_addr0), .wdata0(p_wdata0), .done0(p_done0),
    .req1(1'b0), .rw1(1'b0), .addr1(8'h00), .wdata1(8'h00), .done1(p_done1),
    .rdata(p_rdata), .c_s(p_c_s), .a_d(p_a_d), .r_d(p_r_d), .w_r(p_w_r), .io_port(p_io)
  );

  int   total = 0;
  int   bad   = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      total++;
      if (c_s && io_port != 8'hFF) begin
        bad++;
        $display("FAIL bus_idle_drive: io=%0h with c_s high, want FF", io_port);
      end
      total++;
      if (p_c_s && p_io != 8'hFF) begin
        bad++;
        $display("FAIL p1_gap_drive: io=%0h with c_s high, want FF", p_io);
      end
      total++;
      if (done0 && done1) begin
        bad++;
        $display("FAIL done_both: done0=1 done1=1, want at most one");
      end
    end
  end

  typedef struct {
    int         scen;
    int         cyc;
    logic [3:0] strb;   // {c_s, a_d, r_d, w_r}
    logic [7:0] io;
    logic       d0;
    logic       d1;
    logic [7:0] rd;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int s, input int c, input logic [3:0] st,
                              input logic [7:0] io, input logic d0, input logic d1,
                              input logic [7:0] rd);
    vec_t v;
    v.scen = s; v.cyc = c; v.strb = st; v.io = io; v.d0 = d0; v.d1 = d1; v.rd = rd;
    vecs.push_back(v);
  endfunction

  logic [3:0] cap_strb[16];
  logic [7:0] cap_io[16];
  logic [7:0] cap_rd[16];
  logic       cap_d0[16];
  logic       cap_d1[16];

  task automatic run_scen(input int s);
    for (int c = 0; c < 16; c++) begin
      if (c == 0) begin
        case (s)
          0: begin req0 = 1; rw0 = 1; addr0 = 8'h21; wdata0 = 8'h45; end
          1: begin req1 = 1; rw1 = 0; addr1 = 8'h22; wdata1 = 8'hEE; rtc_data = 8'h37; end
          2: begin req1 = 1; rw1 = 0; addr1 = 8'h33; wdata1 = 8'hEE; rtc_data = 8'h5A; end
          default: begin p_req0 = 1; p_rw0 = 1; p_addr0 = 8'h21; p_wdata0 = 8'h45; end
        endcase
      end
      if (s == 0 && c == 2) begin addr0 = 8'h99; wdata0 = 8'h99; end
      if (s == 2 && c == 3) req1 = 0;
      @(negedge clk);
      if (s == 3) begin
        cap_strb[c] = {p_c_s, p_a_d, p_r_d, p_w_r};
        cap_io[c] = p_io; cap_d0[c] = p_done0; cap_d1[c] = p_done1; cap_rd[c] = p_rdata;
        if (p_done0) p_req0 = 0;
      end else begin
        cap_strb[c] = {c_s, a_d, r_d, w_r};
        cap_io[c] = io_port; cap_d0[c] = done0; cap_d1[c] = done1; cap_rd[c] = rdata;
        if (done0) req0 = 0;
        if (done1) req1 = 0;
      end
      @(posedge clk); #1;
    end
    foreach (vecs[i]) begin
      if (vecs[i].scen == s) begin
        chk($sformatf("s%0d c%0d strobes", s, vecs[i].cyc), cap_strb[vecs[i].cyc], vecs[i].strb);
        chk($sformatf("s%0d c%0d io", s, vecs[i].cyc), cap_io[vecs[i].cyc], vecs[i].io);
        chk($sformatf("s%0d c%0d done0", s, vecs[i].cyc), cap_d0[vecs[i].cyc], vecs[i].d0);
        chk($sformatf("s%0d c%0d done1", s, vecs[i].cyc), cap_d1[vecs[i].cyc], vecs[i].d1);
        chk($sformatf("s%0d c%0d rdata", s, vecs[i].cyc), cap_rd[vecs[i].cyc], vecs[i].rd);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int   nd;
    int   order[4];
    logic prev_done;
    int   k;
    logic found;

    // write 21/45 (PHASE_CYC=4)
    add(0, 0, 4'hF, 8'hFF, 0, 0, 8'h00);
    add(0, 1, 4'h2, 8'h21, 0, 0, 8'h00);
    add(0, 4, 4'h2, 8'h21, 0, 0, 8'h00);
    add(0, 5, 4'hF, 8'hFF, 0, 0, 8'h00);
    add(0, 8, 4'hF, 8'hFF, 0, 0, 8'h00);
    add(0, 9, 4'h6, 8'h45, 0, 0, 8'h00);
    add(0, 12, 4'h6, 8'h45, 0, 0, 8'h00);
    add(0, 13, 4'hF, 8'hFF, 1, 0, 8'h00);
    add(0, 14, 4'hF, 8'hFF, 0, 0, 8'h00);
    // read 22 -> 37
    add(1, 0, 4'hF, 8'hFF, 0, 0, 8'h00);
    add(1, 1, 4'h2, 8'h22, 0, 0, 8'h00);
    add(1, 4, 4'h2, 8'h22, 0, 0, 8'h00);
    add(1, 5, 4'hF, 8'hFF, 0, 0, 8'h00);
    add(1, 9, 4'h5, 8'h37, 0, 0, 8'h00);
    add(1, 12, 4'h5, 8'h37, 0, 0, 8'h00);
    add(1, 13, 4'hF, 8'hFF, 0, 1, 8'h37);
    add(1, 14, 4'hF, 8'hFF, 0, 0, 8'h37);
    // read 33 -> 5A with req1 withdrawn in cycle 3
    add(2, 1, 4'h2, 8'h33, 0, 0, 8'h37);
    add(2, 9, 4'h5, 8'h5A, 0, 0, 8'h37);
    add(2, 12, 4'h5, 8'h5A, 0, 0, 8'h37);
    add(2, 13, 4'hF, 8'hFF, 0, 1, 8'h5A);
    add(2, 14, 4'hF, 8'hFF, 0, 0, 8'h5A);
    add(2, 15, 4'hF, 8'hFF, 0, 0, 8'h5A);
    // write 21/45 on the PHASE_CYC=1 instance
    add(3, 0, 4'hF, 8'hFF, 0, 0, 8'h00);
    add(3, 1, 4'h2, 8'h21, 0, 0, 8'h00);
    add(3, 2, 4'hF, 8'hFF, 0, 0, 8'h00);
    add(3, 3, 4'h6, 8'h45, 0, 0, 8'h00);
    add(3, 4, 4'hF, 8'hFF, 1, 0, 8'h00);
    add(3, 5, 4'hF, 8'hFF, 0, 0, 8'h00);

    reset = 0;
    req0 = 0; rw0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; rw1 = 0; addr1 = 0; wdata1 = 0;
    p_req0 = 0; p_rw0 = 0; p_addr0 = 0; p_wdata0 = 0;
    rtc_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset strobes", {c_s, a_d, r_d, w_r}, 4'hF);
    chk("reset io", io_port, 8'hFF);
    chk("reset dones", {done0, done1}, 2'b00);
    chk("reset rdata", rdata, 8'h00);
    @(posedge clk); #1;
    reset = 1;
    mon_en = 1;

    for (int s = 0; s < 3; s++) run_scen(s);

    // Tie after reset, both held: expect 0,1,0,1 with an idle cycle after each done
    reset = 0;
    @(posedge clk); #1;
    reset = 1;
    rw0 = 1; addr0 = 8'h10; wdata0 = 8'hA0;
    rw1 = 1; addr1 = 8'h11; wdata1 = 8'hA1;
    req0 = 1; req1 = 1;
    nd = 0;
    prev_done = 0;
    for (int c = 0; c < 80 && nd < 4; c++) begin
      @(negedge clk);
      if (prev_done) chk("tie idle after done", {c_s, a_d, r_d, w_r, done0, done1}, 6'b111100);
      prev_done = done0 | done1;
      if (done0 | done1) begin
        order[nd] = int'(done1);
        nd++;
        if (nd == 4) begin req0 = 0; req1 = 0; end
      end
      @(posedge clk); #1;
    end
    chk("tie done count", nd, 4);
    if (nd == 4) begin
      @(negedge clk);
      chk("tie idle after last", {c_s, a_d, r_d, w_r, done0, done1}, 6'b111100);
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) chk($sformatf("tie order %0d", i), order[i], i % 2);
    end
    repeat (2) @(posedge clk);
    #1;

    // Reset in cycle 10 of a write aborts it; held req0 restarts from ADDR
    req0 = 1; rw0 = 1; addr0 = 8'h21; wdata0 = 8'h45;
    repeat (10) @(posedge clk);
    #1;
    chk("pre-abort strobes", {c_s, a_d, r_d, w_r}, 4'h6);
    reset = 0;
    #1;
    chk("abort strobes", {c_s, a_d, r_d, w_r}, 4'hF);
    chk("abort io", io_port, 8'hFF);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("abort no done0", done0, 0);
      @(posedge clk); #1;
    end
    reset = 1;
    @(negedge clk);
    chk("restart idle", {c_s, a_d, r_d, w_r}, 4'hF);
    found = 0;
    k = 1;
    while (k <= 20 && !found) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (k == 1) begin
        chk("restart addr strobes", {c_s, a_d, r_d, w_r}, 4'h2);
        chk("restart addr io", io_port, 8'h21);
      end
      if (done0) begin
        found = 1;
        req0 = 0;
      end else begin
        k++;
      end
    end
    chk("restart done latency", k, 13);
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1;

    run_scen(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
